// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch sequencer.
package fetch_pkg;

   localparam int WORD_W      = 32;
   localparam int ADDR_W_DEF  = 9;
   localparam int TIMEOUT_DEF = 16;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_READ = 3'd2,
      S_INC  = 3'd3,
      S_DONE = 3'd4
   } state_t;

endpackage

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: PC -> MAR, memory read handshake with timeout,
// IR latch, then a one-cycle PC increment strobe and a done pulse.
module fetch_seq
   import fetch_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic              flush,
   input  logic [WORD_W-1:0] pc_in,
   input  logic [WORD_W-1:0] mem_data,
   input  logic              mem_rdy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic [WORD_W-1:0] ir_out,
   output logic              pc_inc,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state, nxt;
   logic [CNT_W-1:0] cnt;
   logic             expired;
   logic             unused_pc;

   // Memory is word addressed; only the low ADDR_W bits of the PC reach the MAR.
   assign unused_pc = ^pc_in[WORD_W-1:ADDR_W];
   assign expired   = (cnt == CNT_LAST);

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE: if (start && !flush) nxt = S_ADDR;
         S_ADDR: nxt = flush ? S_IDLE : S_READ;
         S_READ: begin
            if (flush)        nxt = S_IDLE;
            else if (mem_rdy) nxt = S_INC;
            else if (expired) nxt = S_IDLE;
         end
         S_INC:  nxt = flush ? S_IDLE : S_DONE;
         S_DONE: nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state    <= S_IDLE;
         cnt      <= '0;
         mem_addr <= '0;
         ir_out   <= '0;
         err      <= 1'b0;
      end else begin
         state <= nxt;
         case (state)
            S_IDLE: if (start && !flush) err <= 1'b0;
            S_ADDR: begin
               mem_addr <= pc_in[ADDR_W-1:0];
               cnt      <= '0;
            end
            S_READ: begin
               cnt <= cnt + 1'b1;
               // Flush beats a completing read; a completing read beats timeout.
               if (!flush) begin
                  if (mem_rdy)      ir_out <= mem_data;
                  else if (expired) err    <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Strobes decode the state register alone so no input reaches them combinationally.
   assign mem_rd = (state == S_READ);
   assign pc_inc = (state == S_INC);
   assign done   = (state == S_DONE);
   assign busy   = (state != S_IDLE);

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: vector table through a scoreboard queue,
// plus hand-written sequences for reset, flush and start-in-DONE corners.
module tb_fetch_seq;

   logic        clk, clr, start, flush, mem_rdy;
   logic [31:0] pc_in, mem_data, ir_out;
   logic [8:0]  mem_addr;
   logic        mem_rd, pc_inc, busy, done, err;

   int errors = 0;
   int checks = 0;

   fetch_seq #(.ADDR_W(9), .TIMEOUT(16)) dut (
      .clk(clk), .clr(clr), .start(start), .flush(flush), .pc_in(pc_in),
      .mem_data(mem_data), .mem_rdy(mem_rdy), .mem_addr(mem_addr),
      .mem_rd(mem_rd), .ir_out(ir_out), .pc_inc(pc_inc), .busy(busy),
      .done(done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
      int          rdy_dly;   // READ-cycle index where mem_rdy is raised (99 = never)
      int          flush_rd;  // READ-cycle index where flush is raised (99 = never)
      logic [31:0] exp_addr;
      logic [31:0] exp_ir;
      logic        exp_err;
      int          exp_rd;    // cycles with mem_rd high
      int          exp_inc;   // cycles with pc_inc high
      int          exp_done;  // cycles with done high
      int          exp_dedge; // edge (start sampled at edge 1) where done is seen
   } vec_t;

   vec_t vecs[8];
   vec_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_vec(input vec_t v);
      int n, rd, pci, dn, dedge;
      bit fin;
      vec_t e;
      sb.push_back(v);
      @(negedge clk);
      pc_in = v.pc; mem_data = v.data; start = 1'b1; flush = 1'b0; mem_rdy = 1'b0;
      n = 0; rd = 0; pci = 0; dn = 0; dedge = 0; fin = 0;
      @(posedge clk); n = 1;
      @(negedge clk); start = 1'b0;
      while (!fin && n < 60) begin
         if (mem_rd) begin
            flush   = (rd == v.flush_rd);
            mem_rdy = (rd == v.rdy_dly);
            rd++;
         end else begin
            flush = 1'b0; mem_rdy = 1'b0;
         end
         if (pc_inc) pci++;
         if (done) begin dn++; dedge = n; end
         if (!busy) fin = 1;
         else begin
            @(posedge clk); n++;
            @(negedge clk);
         end
      end
      flush = 1'b0; mem_rdy = 1'b0;
      if (!fin) chk("vec_timeout_idle", 32'(fin), 32'd1);
      e = sb.pop_front();
      chk("vec_mem_addr", 32'(mem_addr), e.exp_addr);
      chk("vec_ir_out",   ir_out,        e.exp_ir);
      chk("vec_err",      32'(err),      32'(e.exp_err));
      chk("vec_rd_cycles", 32'(rd),      32'(e.exp_rd));
      chk("vec_pc_inc",   32'(pci),      32'(e.exp_inc));
      chk("vec_done",     32'(dn),       32'(e.exp_done));
      chk("vec_done_edge", 32'(dedge),   32'(e.exp_dedge));
   endtask

   initial begin
      //          pc            data          dly fl  addr   ir            err rd inc dn edge
      vecs[0] = '{32'h0000_0005, 32'hA5A5_1234, 0, 99, 32'h5,   32'hA5A5_1234, 0, 1, 1, 1, 4};
      vecs[1] = '{32'h0000_0010, 32'h0BAD_F00D, 3, 99, 32'h10,  32'h0BAD_F00D, 0, 4, 1, 1, 7};
      vecs[2] = '{32'h0000_0205, 32'h1111_2222, 0, 99, 32'h5,   32'h1111_2222, 0, 1, 1, 1, 4};
      vecs[3] = '{32'h0000_0033, 32'hFFFF_FFFF, 99, 99, 32'h33, 32'h1111_2222, 1, 16, 0, 0, 0};
      vecs[4] = '{32'h0000_0007, 32'h3333_4444, 1, 99, 32'h7,   32'h3333_4444, 0, 2, 1, 1, 5};
      vecs[5] = '{32'h0000_0100, 32'hDEAD_BEEF, 0, 0,  32'h100, 32'h3333_4444, 0, 1, 0, 0, 0};
      vecs[6] = '{32'hFFFF_FFFF, 32'h7777_8888, 15, 99, 32'h1FF, 32'h7777_8888, 0, 16, 1, 1, 19};
      vecs[7] = '{32'h0000_0042, 32'h9999_AAAA, 5, 2,  32'h42,  32'h7777_8888, 0, 3, 0, 0, 0};

      clr = 1'b1; start = 1'b0; flush = 1'b0; mem_rdy = 1'b0;
      pc_in = 32'h0; mem_data = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_addr", 32'(mem_addr), 32'h0);
      chk("rst_ir_out",   ir_out,        32'h0);
      chk("rst_busy",     32'(busy),     32'h0);
      chk("rst_strobes",  32'({mem_rd, pc_inc, done, err}), 32'h0);
      clr = 1'b0;

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // mem_rdy outside READ must not touch the IR
      mem_rdy = 1'b1; mem_data = 32'hCAFE_0000;
      cyc();
      mem_rdy = 1'b0;
      chk("idle_rdy_ignored", ir_out, 32'h7777_8888);

      // start and flush together in IDLE
      start = 1'b1; flush = 1'b1;
      cyc();
      start = 1'b0; flush = 1'b0;
      chk("idle_start_flush", 32'(busy), 32'h0);

      // flush in ADDR
      pc_in = 32'h0000_0011; start = 1'b1;
      cyc();
      start = 1'b0; flush = 1'b1;
      cyc();
      flush = 1'b0;
      chk("addr_flush_busy", 32'(busy), 32'h0);
      cyc();
      chk("addr_flush_no_rd", 32'(mem_rd), 32'h0);

      // flush in INC: strobe already out, no done afterwards
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      mem_rdy = 1'b1; mem_data = 32'h0000_0055;
      cyc();
      mem_rdy = 1'b0;
      chk("inc_flush_pc_inc", 32'(pc_inc), 32'h1);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      chk("inc_flush_idle", 32'({busy, done}), 32'h0);
      chk("inc_flush_ir", ir_out, 32'h0000_0055);

      // start during DONE ignored; start re-asserted in IDLE begins a fetch
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      mem_rdy = 1'b1; mem_data = 32'h0000_0066;
      cyc();
      mem_rdy = 1'b0;
      cyc();
      chk("done_pulse", 32'(done), 32'h1);
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("done_start_ignored", 32'(busy), 32'h0);
      cyc();
      chk("done_still_idle", 32'(busy), 32'h0);
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("restart_busy", 32'(busy), 32'h1);
      flush = 1'b1;
      cyc();
      flush = 1'b0;

      // clr mid-READ
      pc_in = 32'h0000_0020; start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      chk("pre_clr_mem_rd", 32'(mem_rd), 32'h1);
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      chk("clr_mem_addr", 32'(mem_addr), 32'h0);
      chk("clr_ir_out",   ir_out,        32'h0);
      chk("clr_strobes",  32'({mem_rd, pc_inc, busy, done, err}), 32'h0);
      cyc();
      chk("clr_no_pc_inc", 32'({pc_inc, busy}), 32'h0);

      if (sb.size() != 0) chk("sb_empty", 32'(sb.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
Instruction-fetch sequencer; the reader side of the program counter. On request from the control unit it loads the current PC into its memory address register and runs a memory read handshake. It latches the returned word into the instruction register, then pulses the PC increment strobe. It sits between the PC, the instruction memory port and the IR in the bus-based 32-bit datapath.

Parameters:
ADDR_W, 9, memory word-address width; mem_addr = PC[ADDR_W-1:0] (word addressed, PC steps by 1)
TIMEOUT, 16, max cycles READ waits for mem_rdy before aborting with err

Ports:
clk  in  1  clock, all state updates on posedge
clr  in  1  synchronous active-high reset
start  in  1  fetch request from control unit; sampled only in IDLE
flush  in  1  abort request (branch taken / CON FF write); returns to IDLE
pc_in  in  32  current PC value
mem_data  in  32  memory read data, valid when mem_rdy=1
mem_rdy  in  1  memory read-complete strobe
mem_addr  out  ADDR_W  registered read address (MAR)
mem_rd  out  1  read request, held high throughout READ
ir_out  out  32  instruction register
pc_inc  out  1  one-cycle PC increment strobe
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse: fetch completed, ir_out valid
err  out  1  sticky timeout flag

Behaviour:
- Reset: clr high at a posedge -> state IDLE. mem_addr=0, mem_rd=0, ir_out=0, pc_inc=0, busy=0, done=0, err=0, timeout counter=0. clr overrides every other input, including mid-fetch.
- States: IDLE, ADDR, READ, INC, DONE. Encodings are fixed in the package.
- IDLE: if start=1 and flush=0 -> ADDR, clear err. Otherwise stay.
- ADDR: mem_addr <= pc_in[ADDR_W-1:0]. Counter <= 0. Next state READ.
- READ: mem_rd=1 and the counter increments each cycle.
  - mem_rdy=1 -> ir_out <= mem_data, next INC.
  - Otherwise, if the counter reaches TIMEOUT-1 -> err <= 1, next IDLE, ir_out unchanged.
- INC: pc_inc=1 for exactly this cycle. Next DONE.
- DONE: done=1 for exactly this cycle. Next IDLE. A start during DONE is ignored; start must be seen in IDLE.
- Latency with mem_rdy on the first READ cycle: start at edge 0 -> ADDR at 1, READ at 2, INC at 3 (pc_inc), DONE at 4 (done). Five cycles from start to idle.
- flush=1 in ADDR, READ or INC -> next state IDLE.
  - ir_out is not updated in that cycle.
  - No pc_inc in the following cycle and no done.
  - flush in INC: pc_inc is already high that cycle. The PC write port owns priority, so the PC takes the written value.
- Simultaneous events:
  - flush and mem_rdy in the same READ cycle: flush wins, ir_out unchanged.
  - mem_rdy and timeout on the same cycle: mem_rdy wins, no err.
  - start and flush in IDLE: stay IDLE.
- mem_rdy outside READ is ignored.
- mem_rd, pc_inc, busy and done are decoded from the state register only, so they carry no combinational path from inputs.
- err holds until clr or the next accepted start.

Decomposition:
- Package fetch_pkg holds:
  - state enum/localparams (IDLE=0, ADDR=1, READ=2, INC=3, DONE=4)
  - default ADDR_W and TIMEOUT constants
  - 32-bit word width constant shared with the PC and IR
- No sub-module is needed; the timeout counter is a few lines inside fetch_seq.

Test Plan:
- Reset mid-READ: pc_in=0x20, start, then clr during READ -> next cycle all outputs 0, state IDLE, no pc_inc.
- Basic fetch: pc_in=0x0000_0005, start, mem_rdy=1 with mem_data=0xA5A5_1234 on the first READ cycle -> mem_addr=5, ir_out=0xA5A5_1234, pc_inc one cycle at edge 3, done at edge 4, busy low at edge 5.
- Wait states: mem_rdy delayed 3 cycles -> mem_rd high for 4 cycles, pc_inc and done shifted by +3, err=0.
- Timeout: mem_rdy never asserts -> after 16 READ cycles err=1, state IDLE, ir_out unchanged, no pc_inc. Next start clears err.
- Flush race: flush=1 and mem_rdy=1 in the same READ cycle with mem_data=0xDEAD_BEEF -> ir_out keeps its prior value, no pc_inc, no done, IDLE next cycle.
- Address truncation: pc_in=0x0000_0205 with ADDR_W=9 -> mem_addr=0x005. start during DONE is ignored, and a new fetch starts only when start is re-asserted in IDLE.
